bcd_serial_addsub: RTL and testbench
====================================

# bcd_serial_addsub

Parametrised, digit-serial packed-BCD adder/subtractor: the multi-digit successor to the single-digit combinational BCD adder cell. It processes one BCD digit per clock, least-significant digit first, reusing one decimal-corrected digit adder with a registered inter-digit carry. It supports subtraction via nines' complement and flags non-BCD operand digits. It sits behind a start/done handshake in the datapath that drives the multi-digit display and counter logic.

## Interface
- DIGITS, 4, number of BCD digits per operand (legal range 1..16)
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = add, 1 = subtract; captured with start
- cin  in  1  add: carry-in; subtract: borrow-in; captured with start
- a  in  4*DIGITS  operand A, packed BCD, digit i at bits [4i+3:4i]; captured with start
- b  in  4*DIGITS  operand B, same packing; captured with start
- busy  out  1  high while digits are being processed (RUN)
- done  out  1  one-cycle pulse; result valid
- sum  out  4*DIGITS  packed BCD result, held until the next accepted start
- cout  out  1  add: decimal carry-out; subtract: 1 = no borrow, 0 = borrow
- invalid  out  1  at least one captured digit of a or b was > 9; updated together with done

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> capture a, b, sub, cin and per-digit invalid check; digit index = 0; go to RUN.
  - RUN: process digit[index]; index increments; after the digit DIGITS-1, go to DONE.
  - DONE: go to IDLE unconditionally.
- start in RUN or DONE is ignored. Operands are not re-sampled.
- Effective B digit: b_i if sub=0, else 9 - b_i (4-bit subtract, no clamp).
- Initial carry: cin if sub=0, else ~cin.
- Digit step: t = a_i + b'_i + c (5-bit binary).
  - If t > 9: digit = (t + 6) mod 16, c = 1.
  - Else: digit = t[3:0], c = 0.
- The final c drives cout.
- Subtract semantics: result = A - B - cin.
  - When it is negative: cout=0 and sum holds the ten's complement, 10^DIGITS + A - B - cin.
- Invalid digits are not corrected. The same step rule is applied to them, so the result is deterministic but meaningless, and invalid=1.
- sum digits are written in place as they complete. The upper digits of sum show the previous result until they are overwritten; only the value at done is defined.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, sum=0, cout=0, invalid=0, index=0.
- Reset during RUN or DONE aborts the operation; no done pulse is produced.
- start accepted at edge k:
  - busy=1 from edge k through edge k+DIGITS-1.
  - Digit i is written at edge k+1+i.
  - At edge k+DIGITS the state becomes DONE; done=1, busy=0, and sum/cout/invalid are final for that cycle.
  - Edge k+DIGITS+1: done=0, state=IDLE.
- Start-to-done latency is DIGITS+1 cycles.
- Throughput is one operation per DIGITS+2 cycles; the earliest next accepted start is at edge k+DIGITS+2 (start held high is fine).
- start and rst_n=0 at the same edge: reset wins.
- sum, cout and invalid are stable from done until the next accepted start. They then begin changing at edge k+1 of the new operation.

## Test plan
- Add, DIGITS=4: a=0x1234, b=0x5678, cin=0 -> sum=0x6912, cout=0, invalid=0; done exactly 5 cycles after start, busy high for 4 cycles.
- Carry ripple: a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- Subtract: sub=1, a=0x5000, b=0x1234, cin=0 -> sum=0x3766, cout=1. Also a=0x0000, b=0x0001, cin=0 -> sum=0x9999, cout=0 (borrow).
- Invalid: a=0x00A0, b=0x0000 -> invalid=1 at done. The next operation with a=0x0001, b=0x0002 -> invalid=0, sum=0x0003.
- Handshake: start held high continuously -> starts are accepted every 6 cycles (DIGITS=4). A start pulse in the middle of RUN changes nothing; the result reflects the originally captured operands.
- Reset: rst_n=0 at the 2nd RUN cycle -> all outputs 0 on the next cycle, no done pulse. A following start produces a correct result in 5 cycles. Repeat at DIGITS=1: 0x9 + 0x9 -> sum=0x8, cout=1, latency 2.

Source files
------------

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial packed-BCD adder/subtractor with start/done handshake
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] a_r;
  logic [4*DIGITS-1:0] b_r;
  logic                sub_r;
  logic                carry;
  logic                inv_r;
  logic                inv_in;
  logic                last_digit;
  logic [3:0]          a_d;
  logic [3:0]          b_d;
  logic [3:0]          b_eff;
  logic [3:0]          dig;
  logic [4:0]          t;
  logic                c_nx;

  assign last_digit = (idx == IW'(DIGITS - 1));

  // Flag any operand digit above 9 on the incoming operands, captured with start
  always_comb begin
    inv_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
        inv_in = 1'b1;
      end
    end
  end

  // One decimal-corrected digit adder; subtraction feeds the nines' complement of B
  always_comb begin
    a_d   = a_r[{idx, 2'b00} +: 4];
    b_d   = b_r[{idx, 2'b00} +: 4];
    b_eff = sub_r ? (4'd9 - b_d) : b_d;
    t     = {1'b0, a_d} + {1'b0, b_eff} + {4'b0000, carry};
    if (t > 5'd9) begin
      dig  = t[3:0] + 4'd6;
      c_nx = 1'b1;
    end else begin
      dig  = t[3:0];
      c_nx = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_digit) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, per-digit result write-back and final flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      carry   <= 1'b0;
      inv_r   <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            carry <= sub ? ~cin : cin;
            inv_r <= inv_in;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[{idx, 2'b00} +: 4] <= dig;
          carry                  <= c_nx;
          if (last_digit) begin
            idx     <= '0;
            cout    <= c_nx;
            invalid <= inv_r;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb/tb_bcd_serial_addsub.sv - self-checking bench for bcd_serial_addsub (DIGITS=4 and DIGITS=1)
module tb_bcd_serial_addsub;

  logic        clk;
  logic        rst_n;

  logic        start4, sub4, cin4;
  logic [15:0] a4, b4;
  logic        busy4, done4, cout4, invalid4;
  logic [15:0] sum4;

  logic        start1, sub1, cin1;
  logic [3:0]  a1, b1;
  logic        busy1, done1, cout1, invalid1;
  logic [3:0]  sum1;

  int checks;
  int errors;

  bcd_serial_addsub #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .cin(cin4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4),
    .cout(cout4), .invalid(invalid4)
  );

  bcd_serial_addsub #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .cin(cin1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1),
    .cout(cout1), .invalid(invalid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint bcd2int(input logic [63:0] v, input int d);
    longint r;
    r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] int2bcd(input longint v, input int d);
    logic [63:0] r;
    longint x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] rbcd(input int d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Decimal reference: plain integer add/subtract modulo 10^d
  task automatic model(input logic [63:0] av, input logic [63:0] bv, input bit sv, input bit cv,
                       input int d, output logic [63:0] so, output bit co);
    longint p, x, y, r;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    x = bcd2int(av, d);
    y = bcd2int(bv, d);
    if (!sv) begin
      r  = x + y + longint'(cv);
      co = (r >= p);
      if (co) r = r - p;
    end else begin
      r  = x - y - longint'(cv);
      co = (r >= 0);
      if (!co) r = r + p;
    end
    so = int2bcd(r, d);
  endtask

  task automatic op4(input logic [15:0] av, input logic [15:0] bv, input bit sv, input bit cv,
                     input string tag, output logic [15:0] so, output logic co, output logic io);
    int n;
    int busy_n;
    bit got;
    a4 = av; b4 = bv; sub4 = sv; cin4 = cv; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0; busy_n = 0; got = 1'b0;
    while (!got && n < 20) begin
      if (busy4) busy_n++;
      if (done4) got = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check({tag, "_latency"}, 64'(n + 1), 64'd5);
    check({tag, "_busycycles"}, 64'(busy_n), 64'd4);
    so = sum4; co = cout4; io = invalid4;
    @(posedge clk); #1;
    check({tag, "_donefall"}, {62'd0, done4, busy4}, 64'd0);
  endtask

  task automatic op1(input logic [3:0] av, input logic [3:0] bv, input bit sv, input bit cv,
                     input string tag, output logic [3:0] so, output logic co);
    int n;
    a1 = av; b1 = bv; sub1 = sv; cin1 = cv; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n + 1), 64'd2);
    so = sum1; co = cout1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] s;
    logic        c, inv;
    logic [3:0]  s1;
    logic [63:0] es, ra, rb;
    bit          ec, sv, cv, saw;
    int          t, nd, dt[3];

    checks = 0; errors = 0;
    start4 = 0; sub4 = 0; cin4 = 0; a4 = '0; b4 = '0;
    start1 = 0; sub1 = 0; cin1 = 0; a1 = '0; b1 = '0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_state", {busy4, done4, cout4, invalid4, 48'd0, sum4}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op4(16'h1234, 16'h5678, 0, 0, "add_basic", s, c, inv);
    check("add_basic_sum", 64'(s), 64'h6912);
    check("add_basic_flags", {c, inv}, 64'd0);

    op4(16'h9999, 16'h0001, 0, 0, "ripple", s, c, inv);
    check("ripple_sum", 64'(s), 64'h0000);
    check("ripple_cout", 64'(c), 64'd1);

    op4(16'h0000, 16'h0000, 0, 1, "cin_only", s, c, inv);
    check("cin_only_sum", 64'(s), 64'h0001);
    check("cin_only_cout", 64'(c), 64'd0);

    op4(16'h5000, 16'h1234, 1, 0, "sub_pos", s, c, inv);
    check("sub_pos_sum", 64'(s), 64'h3766);
    check("sub_pos_cout", 64'(c), 64'd1);

    op4(16'h0000, 16'h0001, 1, 0, "sub_neg", s, c, inv);
    check("sub_neg_sum", 64'(s), 64'h9999);
    check("sub_neg_cout", 64'(c), 64'd0);

    op4(16'h00A0, 16'h0000, 0, 0, "invalid", s, c, inv);
    check("invalid_flag", 64'(inv), 64'd1);
    check("invalid_sum", 64'(s), 64'h0100);

    op4(16'h0001, 16'h0002, 0, 0, "after_inv", s, c, inv);
    check("after_inv_flag", 64'(inv), 64'd0);
    check("after_inv_sum", 64'(s), 64'h0003);

    // Random valid operands against the decimal model
    for (int i = 0; i < 24; i++) begin
      ra = rbcd(4); rb = rbcd(4);
      sv = 1'($urandom_range(0, 1)); cv = 1'($urandom_range(0, 1));
      model(ra, rb, sv, cv, 4, es, ec);
      op4(16'(ra), 16'(rb), sv, cv, "rand", s, c, inv);
      check("rand_sum", 64'(s), es);
      check("rand_cout", 64'(c), 64'(ec));
      check("rand_inv", 64'(inv), 64'd0);
    end

    // Random operands with one forced non-BCD digit
    for (int i = 0; i < 6; i++) begin
      ra = rbcd(4); rb = rbcd(4);
      if (i % 2 == 0) ra[4*(i%4) +: 4] = 4'($urandom_range(10, 15));
      else            rb[4*(i%4) +: 4] = 4'($urandom_range(10, 15));
      op4(16'(ra), 16'(rb), 1'(i % 3 == 0), 0, "rand_bad", s, c, inv);
      check("rand_bad_inv", 64'(inv), 64'd1);
    end

    // Start held high: one accepted operation every DIGITS+2 cycles
    a4 = 16'h0042; b4 = 16'h0958; sub4 = 0; cin4 = 0; start4 = 1'b1;
    t = 0; nd = 0;
    while (nd < 3 && t < 40) begin
      @(posedge clk); #1;
      t++;
      if (done4) begin
        dt[nd] = t;
        nd++;
      end
    end
    start4 = 1'b0;
    check("held_count", 64'(nd), 64'd3);
    check("held_first", 64'(dt[0]), 64'd5);
    check("held_gap1", 64'(dt[1] - dt[0]), 64'd6);
    check("held_gap2", 64'(dt[2] - dt[1]), 64'd6);
    check("held_sum", {47'd0, cout4, sum4}, 64'h1000);
    repeat (8) @(posedge clk);
    #1;
    check("held_idle", {62'd0, busy4, done4}, 64'd0);

    // Start pulse in the middle of RUN is ignored
    a4 = 16'h1111; b4 = 16'h2222; sub4 = 0; cin4 = 0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    a4 = 16'h9999; b4 = 16'h9999; sub4 = 1; cin4 = 1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    t = 0;
    while (!done4 && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    check("midrun_done", 64'(done4), 64'd1);
    check("midrun_sum", {47'd0, cout4, sum4}, 64'h3333);
    @(posedge clk); #1;

    // Reset at the second RUN cycle aborts with no done pulse
    a4 = 16'h1234; b4 = 16'h1111; sub4 = 0; cin4 = 0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_outputs", {busy4, done4, cout4, invalid4, 48'd0, sum4}, 64'd0);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) saw = 1'b1;
    end
    check("abort_no_done", 64'(saw), 64'd0);
    op4(16'h4321, 16'h1234, 0, 0, "post_abort", s, c, inv);
    check("post_abort_sum", 64'(s), 64'h5555);

    // Reset and start at the same edge: reset wins
    a4 = 16'h0001; b4 = 16'h0001; start4 = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b0; rst_n = 1'b1;
    check("reset_wins", {62'd0, busy4, done4}, 64'd0);
    @(posedge clk); #1;
    check("reset_wins_idle", 64'(busy4), 64'd0);

    // Single-digit instance
    op1(4'h9, 4'h9, 0, 0, "d1_99", s1, c);
    check("d1_99_sum", 64'(s1), 64'h8);
    check("d1_99_cout", 64'(c), 64'd1);
    for (int x = 0; x < 10; x++) begin
      for (int y = 0; y < 10; y += 3) begin
        sv = 1'($urandom_range(0, 1)); cv = 1'($urandom_range(0, 1));
        model(64'(x), 64'(y), sv, cv, 1, es, ec);
        op1(4'(x), 4'(y), sv, cv, "d1", s1, c);
        check("d1_res", {59'd0, c, s1}, {59'd0, ec, es[3:0]});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
